instruction_fetch: RTL and testbench

Fetches 16-bit instructions from instruction memory and presents them, one at a time, to the decode stage. It sits directly upstream of the control unit and drives its 3-bit `control_opcode`. It consumes the control unit's `jump` decision to redirect the PC. It halts on the HALT opcode (3'b000) and on the unused opcode 3'b111.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/instruction_fetch_if.sv | 34 +++
 rtl/instruction_fetch_program_counter.sv | 27 ++
 rtl/instruction_fetch.sv | 102 ++++++++++
 tb/tb_instruction_fetch.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, instruction field positions and
// the fetch-stage state type. The control unit decodes against the same
// opcode constants.
package cpu_pkg;

  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 13;
  localparam int unsigned TARGET_MSB = 12;

  localparam logic [2:0] HALT          = 3'b000;
  localparam logic [2:0] LOAD_WORD     = 3'b001;
  localparam logic [2:0] STORE_WORD    = 3'b010;
  localparam logic [2:0] JUMP          = 3'b011;
  localparam logic [2:0] ADD           = 3'b100;
  localparam logic [2:0] ADD_IMMEDIATE = 3'b101;
  localparam logic [2:0] SUBTRACT      = 3'b110;
  localparam logic [2:0] ILLEGAL       = 3'b111;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_HOLD,
    ST_HALT
  } fetch_state_t;

  // Opcodes that stop the fetch stage instead of being handed to decode.
  function automatic logic is_stop_op(input logic [2:0] op);
    return (op == HALT) || (op == ILLEGAL);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory request/return, the decode handshake
// and the control unit's jump decision.
interface instruction_fetch_if
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 8
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [2:0]         control_opcode;
  logic               jump;
  logic [PC_W-1:0]    pc;
  logic               halted;
  logic               illegal_op;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, control_opcode, pc,
           halted, illegal_op,
    input  imem_ack, imem_rdata, instr_ready, jump
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, control_opcode, pc,
           halted, illegal_op,
    output imem_ack, imem_rdata, instr_ready, jump
  );

endinterface

// File: rtl/instruction_fetch_program_counter.sv
// Program counter: reset load, modulo-2^PC_W increment and jump load.
module program_counter #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_advance,
  input  logic            i_jump,
  input  logic [PC_W-1:0] i_target,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  // Advance only when decode accepts the presented instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_advance) begin
      r_pc <= i_jump ? i_target : r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding memory request, holds the fetched
// word in IR until decode accepts it, and stops on HALT/ILLEGAL opcodes.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  fetch_state_t       r_state;
  fetch_state_t       w_next_state;
  logic [INSTR_W-1:0] r_ir;
  logic               r_halted;
  logic               r_illegal;
  logic               w_capture;
  logic               w_accept;
  logic [2:0]         w_fetched_op;
  logic [PC_W-1:0]    w_target;
  logic [PC_W-1:0]    w_pc;

  assign w_fetched_op = bus.imem_rdata[OPCODE_MSB:OPCODE_LSB];

  // Jump target is the low PC_W bits of the 13-bit target field.
  if (PC_W <= TARGET_MSB + 1) begin : g_tgt_narrow
    assign w_target = r_ir[PC_W-1:0];
  end else begin : g_tgt_wide
    assign w_target = {{(PC_W - TARGET_MSB - 1){1'b0}}, r_ir[TARGET_MSB:0]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state plus capture/accept strobes; inputs are ignored outside the
  // state that consumes them.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (bus.imem_ack) begin
          w_capture    = 1'b1;
          w_next_state = is_stop_op(w_fetched_op) ? ST_HALT : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.instr_ready) begin
          w_accept     = 1'b1;
          w_next_state = ST_FETCH;
        end
      end
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_FETCH;
    endcase
  end

  // Instruction register and sticky stop flags, loaded on the capturing ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir      <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_capture) begin
      r_ir <= bus.imem_rdata;
      if (is_stop_op(w_fetched_op)) r_halted  <= 1'b1;
      if (w_fetched_op == ILLEGAL)  r_illegal <= 1'b1;
    end
  end

  program_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .i_advance (w_accept),
    .i_jump    (bus.jump),
    .i_target  (w_target),
    .o_pc      (w_pc)
  );

  // Request is gated by rst because the reset state is FETCH.
  assign bus.imem_req       = (r_state == ST_FETCH) && !rst;
  assign bus.imem_addr      = w_pc;
  assign bus.instr_valid    = (r_state == ST_HOLD);
  assign bus.instr          = r_ir;
  assign bus.control_opcode = r_ir[OPCODE_MSB:OPCODE_LSB];
  assign bus.pc             = w_pc;
  assign bus.halted         = r_halted;
  assign bus.illegal_op     = r_illegal;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a latency-programmable memory.
module tb_instruction_fetch;

  logic clk;
  logic rst;

  instruction_fetch_if #(.PC_W(8)) bus ();

  instruction_fetch #(
    .PC_W     (8),
    .RESET_PC (8'd0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [256];
  int unsigned lat;
  int unsigned n_checks;
  int unsigned n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic exp_fetch(input logic [7:0] a);
    step();
    chk("fetch_req", {31'd0, bus.imem_req}, 32'd1);
    chk("fetch_addr", {24'd0, bus.imem_addr}, {24'd0, a});
    chk("fetch_valid", {31'd0, bus.instr_valid}, 32'd0);
  endtask

  task automatic exp_hold(input logic [7:0] p, input logic [15:0] w);
    logic [2:0] op;
    op = w[15:13];
    step();
    chk("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
    chk("hold_pc", {24'd0, bus.pc}, {24'd0, p});
    chk("hold_instr", {16'd0, bus.instr}, {16'd0, w});
    chk("hold_opcode", {29'd0, bus.control_opcode}, {29'd0, op});
  endtask

  // Memory responder: ack after `lat` cycles of continuous request.
  initial begin
    int unsigned cnt;
    cnt = 0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.imem_req) begin
        bus.imem_ack   = (cnt >= lat);
        bus.imem_rdata = mem[bus.imem_addr];
        cnt++;
      end else begin
        bus.imem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    lat      = 0;
    rst      = 1'b1;
    bus.instr_ready = 1'b1;
    bus.jump        = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
    mem[0]   = 16'h8000;
    mem[1]   = 16'hA000;
    mem[2]   = 16'hC000;
    mem[3]   = 16'h8003;
    mem[4]   = 16'h6009;
    mem[5]   = 16'h60FF;
    mem[9]   = 16'h6004;
    mem[255] = 16'h8123;

    // Reset state
    repeat (2) step();
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_illegal", {31'd0, bus.illegal_op}, 32'd0);
    chk("rst_instr", {16'd0, bus.instr}, 32'd0);
    chk("rst_pc", {24'd0, bus.pc}, 32'd0);
    @(posedge clk); #2 rst = 1'b0;

    // Zero-wait sequential fetch
    exp_fetch(8'd0); exp_hold(8'd0, 16'h8000);
    exp_fetch(8'd1); exp_hold(8'd1, 16'hA000);
    exp_fetch(8'd2); exp_hold(8'd2, 16'hC000);

    // Backpressure: ready low for 5 hold cycles, jump asserted but ignored
    exp_fetch(8'd3);
    bus.instr_ready = 1'b0;
    bus.jump        = 1'b1;
    repeat (5) exp_hold(8'd3, 16'h8003);
    bus.instr_ready = 1'b1;
    bus.jump        = 1'b0;
    lat             = 3;

    // Three wait states: address held for four cycles
    repeat (4) exp_fetch(8'd4);
    bus.jump = 1'b1;

    // Jumps taken and not taken
    exp_hold(8'd4, 16'h6009);
    lat = 0;
    exp_fetch(8'd9);
    exp_hold(8'd9, 16'h6004);
    exp_fetch(8'd4);
    bus.jump = 1'b0;
    exp_hold(8'd4, 16'h6009);
    exp_fetch(8'd5);
    bus.jump = 1'b1;
    exp_hold(8'd5, 16'h60FF);
    exp_fetch(8'd255);
    bus.jump = 1'b0;

    // Wrap-around 255 -> 0
    exp_hold(8'd255, 16'h8123);
    exp_fetch(8'd0);
    exp_hold(8'd0, 16'h8000);
    exp_fetch(8'd1);
    exp_hold(8'd1, 16'hA000);

    // Reset while in HOLD: valid drops at once, IR and PC cleared
    #2 rst = 1'b1;
    #1;
    chk("rsthold_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rsthold_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rsthold_instr", {16'd0, bus.instr}, 32'd0);
    chk("rsthold_pc", {24'd0, bus.pc}, 32'd0);
    lat = 3;
    @(posedge clk); #2 rst = 1'b0;

    // Reset while waiting for an ack
    exp_fetch(8'd0);
    exp_fetch(8'd0);
    #2 rst = 1'b1;
    #1;
    chk("rstwait_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rstwait_valid", {31'd0, bus.instr_valid}, 32'd0);
    lat = 0;
    @(posedge clk); #2 rst = 1'b0;
    exp_fetch(8'd0);
    exp_hold(8'd0, 16'h8000);

    // HALT opcode
    #2 rst = 1'b1;
    mem[0] = 16'h0000;
    @(posedge clk); #2 rst = 1'b0;
    exp_fetch(8'd0);
    chk("halt_pre", {31'd0, bus.halted}, 32'd0);
    step();
    chk("halt_halted", {31'd0, bus.halted}, 32'd1);
    chk("halt_illegal", {31'd0, bus.illegal_op}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      chk("halt_idle_req", {31'd0, bus.imem_req}, 32'd0);
      chk("halt_idle_valid", {31'd0, bus.instr_valid}, 32'd0);
      step();
    end
    chk("halt_sticky", {31'd0, bus.halted}, 32'd1);

    // ILLEGAL opcode
    rst = 1'b1;
    #1;
    chk("illrst_halted", {31'd0, bus.halted}, 32'd0);
    mem[0] = 16'hE000;
    @(posedge clk); #2 rst = 1'b0;
    exp_fetch(8'd0);
    step();
    chk("ill_halted", {31'd0, bus.halted}, 32'd1);
    chk("ill_illegal", {31'd0, bus.illegal_op}, 32'd1);
    chk("ill_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("ill_req", {31'd0, bus.imem_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
